// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a circular FIFO and are shifted out LSB first on txd.
// Latency: a byte pushed into an empty FIFO with the FSM idle is popped one clock later; txd drops one clock after that.
// Backpressure: tx_ready is low while the FIFO holds 2**LOG2_DEPTH bytes; a held tx_valid is taken once a slot frees.
module uart_tx_buffered #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int LOG2_DEPTH       = 4,
    parameter int STOP_BITS        = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [7:0]          tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                txd,
    output logic                busy,
    output logic [LOG2_DEPTH:0] fifo_count
);
    localparam int DEPTH    = 1 << LOG2_DEPTH;
    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int BAUD_W   = $clog2(BIT_CLKS);

    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(BIT_CLKS - 1);
    localparam logic [BAUD_W-1:0]     BAUD_ONE  = BAUD_W'(1);
    localparam logic [LOG2_DEPTH:0]   FULL_CNT  = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0]   CNT_ONE   = (LOG2_DEPTH + 1)'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);
    localparam logic [2:0]            STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic [7:0]            mem_q [DEPTH];

    logic push;
    logic pop;
    logic bit_end;
    logic fifo_has_data;

    // Ready depends only on the registered count, so a pop this cycle cannot raise it early.
    assign tx_ready      = (count_q != FULL_CNT);
    assign push          = tx_valid && tx_ready;
    assign fifo_has_data = (count_q != '0);
    assign bit_end       = (baud_q == BAUD_LAST);
    assign fifo_count    = count_q;
    assign busy          = (state_q != IDLE) || fifo_has_data;
    assign txd           = txd_q;

    // FIFO storage: written on an accepted push; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop moves both pointers and leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Bit-timing FSM: one baud counter spans every bit; bit_idx counts data bits and then stop bits.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_has_data) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    state_d   = START;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        // Chain straight into the next start bit so queued frames leave no idle gap.
                        if (fifo_has_data) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the current state, so txd moves one clock after each FSM transition.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame, forces the line high and empties the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
